// File: rtl/sevenseg_capture.sv
// Recovers hex digits from a multiplexed active-low seven-segment display by
// capturing each digit after it has been stable; optional decimal point via SEVENSEG_CAPTURE_DP_EN.
module sevenseg_capture #(
    parameter int N_DIGITS      = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              segments_in,
    input  logic [N_DIGITS-1:0]     anodes_in,
    input  logic                    clear,
`ifdef SEVENSEG_CAPTURE_DP_EN
    input  logic                    dp_in,
    output logic [N_DIGITS-1:0]     dp_out,
`endif
    output logic [4*N_DIGITS-1:0]   digits_out,
    output logic [N_DIGITS-1:0]     valid_out,
    output logic [N_DIGITS-1:0]     err_out,
    output logic                    frame_done
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [N_DIGITS-1:0]     anode_q, anode_d;
    logic [7:0]              smp_q, smp_d;
    logic [4*N_DIGITS-1:0]   digits_q, digits_d;
    logic [N_DIGITS-1:0]     valid_q, valid_d;
    logic [N_DIGITS-1:0]     err_q, err_d;
    logic [N_DIGITS-1:0]     seen_q, seen_d;
    logic                    frame_done_q, frame_done_d;
`ifdef SEVENSEG_CAPTURE_DP_EN
    logic [N_DIGITS-1:0]     dp_q, dp_d;
    logic                    dp_s;
    assign dp_s = dp_in;
`else
    logic                    dp_s;
    assign dp_s = 1'b1;
`endif

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: decode = {1'b1, 4'h0};
            7'b1001111: decode = {1'b1, 4'h1};
            7'b0010010: decode = {1'b1, 4'h2};
            7'b0000110: decode = {1'b1, 4'h3};
            7'b1001100: decode = {1'b1, 4'h4};
            7'b0100100: decode = {1'b1, 4'h5};
            7'b0100000: decode = {1'b1, 4'h6};
            7'b0001111: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0000100: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b1100000: decode = {1'b1, 4'hB};
            7'b0110001: decode = {1'b1, 4'hC};
            7'b1000010: decode = {1'b1, 4'hD};
            7'b0110000: decode = {1'b1, 4'hE};
            7'b0111000: decode = {1'b1, 4'hF};
            default:    decode = {1'b0, 4'h0};
        endcase
    endfunction

    logic [N_DIGITS-1:0] an_low;
    logic                legal, same, capture;
    logic [IW-1:0]       idx;
    logic [7:0]          sample;
    logic [4:0]          dec;

    always_comb begin
        an_low  = ~anodes_in;
        legal   = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
        sample  = {dp_s, segments_in};
        same    = (anode_q == anodes_in) && (smp_q == sample);
        dec     = decode(segments_in);
        idx     = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (an_low[i]) idx = IW'(i);

        state_d      = state_q;
        cnt_d        = cnt_q;
        anode_d      = anode_q;
        smp_d        = smp_q;
        digits_d     = digits_q;
        valid_d      = valid_q;
        err_d        = err_q;
        capture      = 1'b0;
`ifdef SEVENSEG_CAPTURE_DP_EN
        dp_d         = dp_q;
`endif
        // A full mask reports the frame and restarts collection on the next edge.
        frame_done_d = &seen_q;
        seen_d       = frame_done_d ? '0 : seen_q;

        if (!legal) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q != IDLE && same) begin
            if (state_q == TRACK) begin
                cnt_d = (cnt_q >= STABLE_C) ? cnt_q : cnt_q + 1'b1;
                if (cnt_d == STABLE_C) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
        end else begin
            anode_d = anodes_in;
            smp_d   = sample;
            cnt_d   = CW'(1);
            state_d = TRACK;
            if (STABLE_C == CW'(1)) begin
                capture = 1'b1;
                state_d = HOLD;
            end
        end

        if (capture) begin
            if (dec[4]) begin
                digits_d[idx*4 +: 4] = dec[3:0];
                valid_d[idx]         = 1'b1;
                err_d[idx]           = 1'b0;
                seen_d[idx]          = 1'b1;
`ifdef SEVENSEG_CAPTURE_DP_EN
                dp_d[idx]            = ~dp_s;
`endif
            end else if (segments_in != 7'h7F) begin
                err_d[idx] = 1'b1;
            end
        end

        if (clear) begin
            state_d      = IDLE;
            cnt_d        = '0;
            digits_d     = '0;
            valid_d      = '0;
            err_d        = '0;
            seen_d       = '0;
            frame_done_d = 1'b0;
`ifdef SEVENSEG_CAPTURE_DP_EN
            dp_d         = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            anode_q      <= '1;
            smp_q        <= '1;
            digits_q     <= '0;
            valid_q      <= '0;
            err_q        <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
`ifdef SEVENSEG_CAPTURE_DP_EN
            dp_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            anode_q      <= anode_d;
            smp_q        <= smp_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
`ifdef SEVENSEG_CAPTURE_DP_EN
            dp_q         <= dp_d;
`endif
        end
    end

    assign digits_out = digits_q;
    assign valid_out  = valid_q;
    assign err_out    = err_q;
    assign frame_done = frame_done_q;
`ifdef SEVENSEG_CAPTURE_DP_EN
    assign dp_out     = dp_q;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture with default parameters (8 digits, 4 stable cycles).
module tb_sevenseg_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  segments_in = 7'h7F;
    logic [7:0]  anodes_in = 8'hFF;
    logic        clear = 1'b0;
    logic [31:0] digits_out;
    logic [7:0]  valid_out;
    logic [7:0]  err_out;
    logic        frame_done;

    int pass_cnt = 0;
    int total = 0;
    int fd_cnt = 0;

    sevenseg_capture dut (
        .clk(clk), .reset_n(reset_n), .segments_in(segments_in), .anodes_in(anodes_in),
        .clear(clear), .digits_out(digits_out), .valid_out(valid_out), .err_out(err_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: seg_of = 7'b0000001;  1: seg_of = 7'b1001111;
            2: seg_of = 7'b0010010;  3: seg_of = 7'b0000110;
            4: seg_of = 7'b1001100;  5: seg_of = 7'b0100100;
            6: seg_of = 7'b0100000;  7: seg_of = 7'b0001111;
            8: seg_of = 7'b0000000;  9: seg_of = 7'b0000100;
            10: seg_of = 7'b0001000; 11: seg_of = 7'b1100000;
            12: seg_of = 7'b0110001; 13: seg_of = 7'b1000010;
            14: seg_of = 7'b0110000; default: seg_of = 7'b0111000;
        endcase
    endfunction

    // Drive one clock of inputs, then sample just after the edge.
    task automatic cyc(input logic [7:0] an, input logic [6:0] sg, input logic clr);
        anodes_in = an; segments_in = sg; clear = clr;
        @(posedge clk); #1;
        if (frame_done) fd_cnt++;
    endtask

    task automatic scan(input int first, input int last);
        for (int d = first; d <= last; d++)
            for (int k = 0; k < 4; k++) cyc(~(8'h01 << d), seg_of(d), 1'b0);
    endtask

    task automatic test_reset();
        total++; if (digits_out !== 32'h0) $display("FAIL reset_digits got %h exp %h", digits_out, 32'h0); else pass_cnt++;
        total++; if (valid_out !== 8'h0) $display("FAIL reset_valid got %h exp %h", valid_out, 8'h0); else pass_cnt++;
        total++; if (err_out !== 8'h0) $display("FAIL reset_err got %h exp %h", err_out, 8'h0); else pass_cnt++;
        total++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b exp 0", frame_done); else pass_cnt++;
    endtask

    task automatic test_capture();
        cyc(8'hFF, 7'h7F, 1'b1);
        for (int k = 0; k < 3; k++) cyc(8'hFE, 7'b0010010, 1'b0);
        total++; if (valid_out !== 8'h00) $display("FAIL cap_early_valid got %h exp %h", valid_out, 8'h00); else pass_cnt++;
        cyc(8'hFE, 7'b0010010, 1'b0);
        total++; if (valid_out !== 8'h01) $display("FAIL cap_valid got %h exp %h", valid_out, 8'h01); else pass_cnt++;
        total++; if (digits_out !== 32'h2) $display("FAIL cap_digit got %h exp %h", digits_out, 32'h2); else pass_cnt++;
        cyc(8'hFE, 7'b0010010, 1'b0);
        total++; if (digits_out !== 32'h2 || valid_out !== 8'h01)
            $display("FAIL cap_hold got %h/%h exp %h/%h", digits_out, valid_out, 32'h2, 8'h01); else pass_cnt++;
    endtask

    task automatic test_frame();
        cyc(8'hFF, 7'h7F, 1'b1);
        fd_cnt = 0;
        scan(0, 7);
        cyc(8'hFF, 7'h7F, 1'b0);
        cyc(8'hFF, 7'h7F, 1'b0);
        cyc(8'hFF, 7'h7F, 1'b0);
        total++; if (digits_out !== 32'h76543210) $display("FAIL frame_digits got %h exp %h", digits_out, 32'h76543210); else pass_cnt++;
        total++; if (valid_out !== 8'hFF) $display("FAIL frame_valid got %h exp %h", valid_out, 8'hFF); else pass_cnt++;
        total++; if (fd_cnt !== 1) $display("FAIL frame_pulses got %0d exp 1", fd_cnt); else pass_cnt++;
    endtask

    task automatic test_err();
        for (int k = 0; k < 6; k++) cyc(8'hF7, 7'b1111110, 1'b0);
        total++; if (err_out !== 8'h08) $display("FAIL err_set got %h exp %h", err_out, 8'h08); else pass_cnt++;
        total++; if (digits_out !== 32'h76543210) $display("FAIL err_digits got %h exp %h", digits_out, 32'h76543210); else pass_cnt++;
        total++; if (valid_out !== 8'hFF) $display("FAIL err_valid got %h exp %h", valid_out, 8'hFF); else pass_cnt++;
        for (int k = 0; k < 4; k++) cyc(8'hF7, 7'b0001000, 1'b0);
        total++; if (err_out !== 8'h00) $display("FAIL err_clr got %h exp %h", err_out, 8'h00); else pass_cnt++;
        total++; if (digits_out !== 32'h7654A210) $display("FAIL err_a got %h exp %h", digits_out, 32'h7654A210); else pass_cnt++;
    endtask

    task automatic test_glitch();
        bit bad = 0;
        cyc(8'hFF, 7'h7F, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc(8'hFC, 7'b0000001, 1'b0);
            if (valid_out !== 8'h0 || err_out !== 8'h0) bad = 1;
        end
        for (int k = 0; k < 3; k++) begin
            cyc(8'hFE, 7'b0000001, 1'b0);
            if (valid_out !== 8'h0 || err_out !== 8'h0) bad = 1;
        end
        cyc(8'hFF, 7'h7F, 1'b0);
        total++; if (bad) $display("FAIL glitch_capture got 1 exp 0"); else pass_cnt++;
        total++; if (valid_out !== 8'h0) $display("FAIL glitch_valid got %h exp %h", valid_out, 8'h0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        scan(3, 3);
        cyc(8'hFD, seg_of(5), 1'b0);
        cyc(8'hFD, seg_of(5), 1'b0);
        #2 reset_n = 1'b0;
        #1;
        total++; if (digits_out !== 32'h0 || valid_out !== 8'h0 || err_out !== 8'h0 || frame_done !== 1'b0)
            $display("FAIL rst_mid_outs got %h/%h/%h/%b exp 0", digits_out, valid_out, err_out, frame_done); else pass_cnt++;
        @(posedge clk); #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) cyc(8'hFD, seg_of(5), 1'b0);
        total++; if (valid_out !== 8'h0) $display("FAIL rst_mid_early got %h exp %h", valid_out, 8'h0); else pass_cnt++;
        cyc(8'hFD, seg_of(5), 1'b0);
        total++; if (valid_out !== 8'h02) $display("FAIL rst_mid_valid got %h exp %h", valid_out, 8'h02); else pass_cnt++;
        total++; if (digits_out !== 32'h50) $display("FAIL rst_mid_digit got %h exp %h", digits_out, 32'h50); else pass_cnt++;
    endtask

    task automatic test_clear_capture();
        cyc(8'hFF, 7'h7F, 1'b1);
        scan(0, 6);
        for (int k = 0; k < 3; k++) cyc(8'h7F, seg_of(7), 1'b0);
        fd_cnt = 0;
        cyc(8'h7F, seg_of(7), 1'b1);
        total++; if (digits_out !== 32'h0 || valid_out !== 8'h0 || err_out !== 8'h0)
            $display("FAIL clrcap_outs got %h/%h/%h exp 0", digits_out, valid_out, err_out); else pass_cnt++;
        for (int k = 0; k < 3; k++) cyc(8'hFF, 7'h7F, 1'b0);
        total++; if (fd_cnt !== 0) $display("FAIL clrcap_fd got %0d exp 0", fd_cnt); else pass_cnt++;
        total++; if (valid_out !== 8'h0) $display("FAIL clrcap_valid got %h exp %h", valid_out, 8'h0); else pass_cnt++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_capture();
        test_frame();
        test_err();
        test_glitch();
        test_reset_mid();
        test_clear_capture();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
